// File: rtl/proc_mem_slave.sv
// Word-addressed 16-bit data memory slave on the processor ready/valid bus with wait states.
// Optional PROC_MEM_WAIT_LFSR_EN adds 0..3 pseudo-random extra wait states per transfer.
module proc_mem_slave #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        valid,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef PROC_MEM_WAIT_LFSR_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 4;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_load;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          enter_resp;
  logic [15:0]   rd_next;

  assign idx      = addr[AW-1:0];
  assign in_range = (addr[15:AW] == '0);
  assign rd_next  = in_range ? mem[idx] : 16'h0000;

`ifdef PROC_MEM_WAIT_LFSR_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  // x^8 + x^6 + x^5 + x^4 + 1, current value picks the extra wait of this request
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign wait_load = CW'(WAIT_CYCLES) + CW'(lfsr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (state == StIdle && valid) begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end
`else
  assign wait_load = CW'(WAIT_CYCLES);
`endif

  always_comb begin
    enter_resp = 1'b0;
    case (state)
      StIdle:  enter_resp = valid && (wait_load == '0);
      StWait:  enter_resp = valid && (cnt == CW'(1));
      default: enter_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 16'h0000;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && !in_range;
      if (enter_resp && !we) begin
        rdata <= rd_next;
      end
      case (state)
        StIdle: begin
          if (valid) begin
            cnt   <= wait_load;
            state <= (wait_load == '0) ? StResp : StWait;
          end
        end
        StWait: begin
          // master withdrawing the request abandons it without touching memory
          if (!valid) begin
            state <= StIdle;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= StResp;
            end
          end
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Write commits on the handshake edge; a reset during RESP clears ready and drops it.
  always_ff @(posedge clk) begin
    if (ready && valid && we && in_range) begin
      mem[idx] <= wdata;
    end
  end

endmodule
